dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 64-word data memory.
- Requester 0 is the core load/store port; requester 1 is the debug/loader port used to preload or inspect data memory.
- Requests are serialised with a req/ack handshake and fair round-robin selection.
- Drives the memory's MemRead, MemWrite, address and write-data inputs; returns read data and a one-cycle ack to the winner.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory address bus.
- DATA_W, 32, data width.
- MEM_LAT, 1, number of ACCESS cycles per transaction (legal 1..15; elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  core request; held until c_ack.
- c_we  in  1  core write enable (1 = store, 0 = load).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core store data.
- c_ack  out  1  one-cycle completion pulse to core.
- c_rdata  out  DATA_W  core load data; valid with c_ack, held until next core read completes.
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  debug port, same semantics as core.
- d_ack  out  1  one-cycle completion pulse to debug port.
- d_rdata  out  DATA_W  debug read data, same rules as c_rdata.
- m_read  out  1  memory MemRead.
- m_write  out  1  memory MemWrite.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data (combinational from m_addr/m_read).
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  current or last granted requester (0 = core, 1 = debug).

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset values:
  - state = IDLE; all ack, m_read, m_write and busy = 0.
  - m_addr, m_wdata, c_rdata, d_rdata = 0; owner = 0.
  - Round-robin pointer last = 1, so the core wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only here.
  - Only c_req high: grant core. Only d_req high: grant debug. Both high: grant the requester != last.
  - On grant, latch we/addr/wdata of the winner, set owner, load cnt = MEM_LAT-1, go to ACCESS.
  - No request: stay in IDLE. m_addr/m_wdata hold their last values; m_read and m_write = 0.
- ACCESS:
  - m_addr and m_wdata driven from the latched values.
  - Reads: m_read = 1 for every ACCESS cycle.
  - Writes: m_write = 1 only in the final ACCESS cycle (cnt == 0), giving exactly one memory write edge.
  - cnt decrements each cycle.
  - When cnt == 0: for reads, capture m_rdata into the owner's rdata register. Go to DONE.
- DONE:
  - Assert ack of owner for exactly one cycle; the rdata register already holds the value.
  - Set last = owner, go to IDLE. m_read and m_write = 0.
- Timing, with req high in IDLE at cycle 0:
  - ACCESS occupies cycles 1..MEM_LAT; ack in cycle MEM_LAT+1.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack. Only the latched copies are used after grant, so later changes are ignored.
  - Req must be low in the cycle after ack; a high req there is a new transaction.
- Losing requester keeps req high and is granted in the next IDLE cycle. Worst-case wait is one foreign transaction.
- A requester that drops req before grant is never granted; no ack is produced.
- Writes leave the rdata registers unchanged.
- Reset mid-transaction:
  - Immediate return to IDLE, no ack.
  - If reset arrives before the final ACCESS cycle edge, no memory write occurs.
  - The rdata registers are cleared.
- No address translation: m_addr equals the requester address unmodified.

Test Plan:
- Reset, then idle: all outputs 0, busy=0, owner=0; no m_read/m_write for 20 cycles.
- Core store then load, MEM_LAT=1:
  - c_we=1, c_addr=5, c_wdata=0xDEADBEEF → m_write high exactly one cycle (cycle 1), c_ack in cycle 2.
  - Then c_we=0, c_addr=5 → c_ack with c_rdata=0xDEADBEEF in cycle 2 of that transaction.
- Simultaneous requests from reset: core (addr 1) and debug (addr 2) both req in cycle 0 → core acked at cycle 2, debug granted at cycle 3 and acked at cycle 5.
- Round-robin: both req continuously for 6 transactions → ack order core, debug, core, debug, core, debug; no requester gets two in a row.
- MEM_LAT=4 debug read of addr 7 holding 0x1234 → m_read high in cycles 1–4, d_ack in cycle 5, d_rdata=0x1234; c_rdata unchanged.
- Reset asserted in cycle 2 of a MEM_LAT=4 core write → no m_write pulse, no c_ack, busy=0 immediately; memory at that address still holds its prior value.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared data memory.
// Core (port c) and debug (port d) requests are serialised IDLE -> ACCESS -> DONE.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("dmem_arbiter: MEM_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic               r_owner;
  logic               r_last;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_c_rdata;
  logic [DATA_W-1:0]  r_d_rdata;
  logic               w_grant;
  logic               w_winner;
  logic               w_final;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_grant  = c_req | d_req;
    w_winner = (c_req && d_req) ? ~r_last : d_req;
    w_final  = (r_cnt == 4'd0);
  end

  always_comb begin
    w_state_next = r_state;
    m_read       = 1'b0;
    m_write      = 1'b0;
    c_ack        = 1'b0;
    d_ack        = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_grant) w_state_next = ACCESS;
      end
      ACCESS: begin
        m_read  = ~r_we;
        // A write strobes only in the last access cycle: one memory write edge.
        m_write = r_we & w_final;
        if (w_final) w_state_next = DONE;
      end
      DONE: begin
        c_ack        = ~r_owner;
        d_ack        = r_owner;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_we    <= w_winner ? d_we    : c_we;
            r_addr  <= w_winner ? d_addr  : c_addr;
            r_wdata <= w_winner ? d_wdata : c_wdata;
            r_cnt   <= 4'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (!w_final) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_we) begin
            if (r_owner) r_d_rdata <= m_rdata;
            else         r_c_rdata <= m_rdata;
          end
        end
        DONE: r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign owner   = r_owner;
  assign c_rdata = r_c_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=4,
// each attached to a 64-word memory; expectations come from a word-level memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        req     [2][2];
  logic        we      [2][2];
  logic [31:0] addr    [2][2];
  logic [31:0] wdata   [2][2];
  logic        ack     [2][2];
  logic [31:0] rdata   [2][2];
  logic        m_read  [2];
  logic        m_write [2];
  logic        busy    [2];
  logic        owner   [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 4;
    logic [31:0] mem [64];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(rst[gi]),
      .c_req(req[gi][0]), .c_we(we[gi][0]), .c_addr(addr[gi][0]), .c_wdata(wdata[gi][0]),
      .c_ack(ack[gi][0]), .c_rdata(rdata[gi][0]),
      .d_req(req[gi][1]), .d_we(we[gi][1]), .d_addr(addr[gi][1]), .d_wdata(wdata[gi][1]),
      .d_ack(ack[gi][1]), .d_rdata(rdata[gi][1]),
      .m_read(m_read[gi]), .m_write(m_write[gi]), .m_addr(m_addr[gi]), .m_wdata(m_wdata[gi]),
      .m_rdata(m_rdata[gi]), .busy(busy[gi]), .owner(owner[gi])
    );

    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) if (m_write[gi]) mem[m_addr[gi][5:0]] <= m_wdata[gi];
    assign m_rdata[gi] = m_read[gi] ? mem[m_addr[gi][5:0]] : 32'h0;
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q   [2][2][$];
  logic [31:0] ref_mem [2][64];
  logic [31:0] last_rd [2][2];
  int          ack_cnt [2][2];
  int          total = 0;
  int          bad   = 0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops the owner's expected entry and checks data and owner.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rst[k] && ack[k][p]) begin
          ack_cnt[k][p]++;
          if (exp_q[k][p].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack dut%0d port%0d: got ack want none", k, p);
          end else begin
            mon_e = exp_q[k][p].pop_front();
            check("ack_rdata", rdata[k][p], mon_e.rdata);
            check("ack_owner", 32'(owner[k]), 32'(p));
            $display("ack dut%0d port%0d we=%0b addr=%0d rdata=%h", k, p, mon_e.we, mon_e.addr, rdata[k][p]);
          end
        end
      end
    end
  end

  // One transaction: issue, push the model's expectation, wait (bounded) for ack.
  task automatic txn(input int k, input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output int ack_cyc,
                     output logic [31:0] rd_tr, output logic [31:0] wr_tr);
    exp_t        e;
    int          cyc;
    logic [31:0] prev_addr;
    logic [31:0] prev_wd;
    @(posedge clk); #1;
    req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
    e.we = w;
    e.addr = a;
    if (w) begin
      ref_mem[k][a[5:0]] = d;
      e.rdata = last_rd[k][p];
    end else begin
      e.rdata = ref_mem[k][a[5:0]];
      last_rd[k][p] = e.rdata;
    end
    exp_q[k][p].push_back(e);
    cyc = 0; ack_cyc = -1; rd_tr = 32'h0; wr_tr = 32'h0;
    prev_addr = 32'h0; prev_wd = 32'h0;
    while (ack_cyc < 0 && cyc < 64) begin
      @(negedge clk);
      if (cyc < 32) begin
        rd_tr[cyc] = m_read[k];
        wr_tr[cyc] = m_write[k];
      end
      if (ack[k][p]) begin
        ack_cyc = cyc;
      end else begin
        prev_addr = m_addr[k];
        prev_wd   = m_wdata[k];
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (ack_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout dut%0d port%0d: got no ack want ack within 64 cycles", k, p);
    end else begin
      check("bus_addr", prev_addr, a);
      if (w) check("bus_wdata", prev_wd, d);
    end
    @(posedge clk); #1;
    req[k][p] = 1'b0;
  endtask

  task automatic do_reset(input int k);
    @(posedge clk); #1;
    rst[k] = 1'b1;
    for (int p = 0; p < 2; p++) begin
      exp_q[k][p].delete();
      last_rd[k][p] = 32'h0;
      req[k][p] = 1'b0;
    end
    #1 check("reset_busy", 32'(busy[k]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst[k] = 1'b0;
  endtask

  task automatic rand_port(input int k, input int p, input int n);
    int          ac;
    logic [31:0] tr;
    logic [31:0] tw;
    logic        w;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      w = 1'($urandom_range(0, 1));
      a = (p == 1) ? 32'($urandom_range(32, 63)) : 32'($urandom_range(0, 31));
      txn(k, p, w, a, $urandom, ac, tr, tw);
    end
  endtask

  int          a0, a1, wcount, acks_before;
  logic [31:0] rd0, wr0, rd1, wr1;
  int          ord[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; we[k][p] = 1'b0; addr[k][p] = 32'h0; wdata[k][p] = 32'h0;
        last_rd[k][p] = 32'h0; ack_cnt[k][p] = 0;
      end
      for (int i = 0; i < 64; i++) ref_mem[k][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Idle after reset: everything quiet for 20 cycles.
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        check("idle_ctl", {26'h0, busy[k], m_read[k], m_write[k], owner[k], ack[k][0], ack[k][1]}, 32'h0);
    end
    for (int k = 0; k < 2; k++) begin
      check("reset_maddr", m_addr[k], 32'h0);
      check("reset_mwdata", m_wdata[k], 32'h0);
      check("reset_crdata", rdata[k][0], 32'h0);
      check("reset_drdata", rdata[k][1], 32'h0);
    end

    // Tie straight out of reset: core first.
    fork
      txn(0, 0, 1'b0, 32'd1, 32'h0, a0, rd0, wr0);
      txn(0, 1, 1'b0, 32'd2, 32'h0, a1, rd1, wr1);
    join
    check("tie_reset_core_ack_cyc", 32'(a0), 32'd2);
    check("tie_reset_dbg_ack_cyc", 32'(a1), 32'd5);

    // Core store then load, MEM_LAT=1.
    txn(0, 0, 1'b1, 32'd5, 32'hDEADBEEF, a0, rd0, wr0);
    check("store_ack_cyc", 32'(a0), 32'd2);
    check("store_mwrite_trace", wr0, 32'h2);
    txn(0, 0, 1'b0, 32'd5, 32'h0, a0, rd0, wr0);
    check("load_ack_cyc", 32'(a0), 32'd2);
    check("load_mread_trace", rd0, 32'h2);
    check("load_crdata", rdata[0][0], 32'hDEADBEEF);

    // Tie after a core transaction: debug first.
    fork
      txn(0, 0, 1'b0, 32'd3, 32'h0, a0, rd0, wr0);
      txn(0, 1, 1'b0, 32'd4, 32'h0, a1, rd1, wr1);
    join
    check("tie_after_core_dbg_ack_cyc", 32'(a1), 32'd2);
    check("tie_after_core_core_ack_cyc", 32'(a0), 32'd5);

    // Round-robin with continuous requests from reset.
    do_reset(0);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          txn(0, 0, 1'b0, 32'(10 + i), 32'h0, a0, rd0, wr0);
          ord.push_back(0);
        end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          txn(0, 1, 1'b0, 32'(20 + i), 32'h0, a1, rd1, wr1);
          ord.push_back(1);
        end
      end
    join
    check("rr_count", 32'(ord.size()), 32'd6);
    for (int i = 0; i < ord.size(); i++) check("rr_order", 32'(ord[i]), 32'(i % 2));

    // MEM_LAT=4: debug preload then read of addr 7.
    txn(1, 1, 1'b1, 32'd7, 32'h1234, a1, rd1, wr1);
    check("lat4_write_ack_cyc", 32'(a1), 32'd5);
    check("lat4_mwrite_trace", wr1, 32'h10);
    txn(1, 1, 1'b0, 32'd7, 32'h0, a1, rd1, wr1);
    check("lat4_read_ack_cyc", 32'(a1), 32'd5);
    check("lat4_mread_trace", rd1, 32'h1E);
    check("lat4_drdata", rdata[1][1], 32'h1234);
    check("lat4_crdata_unchanged", rdata[1][0], 32'h0);

    // Debug request withdrawn while the arbiter is busy: never acked.
    acks_before = ack_cnt[1][1];
    fork
      txn(1, 0, 1'b1, 32'd8, 32'h5A5A5A5A, a0, rd0, wr0);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 32'd20;
        @(posedge clk); #1;
        req[1][1] = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("withdrawn_no_ack", 32'(ack_cnt[1][1] - acks_before), 32'h0);

    // Reset in cycle 2 of a MEM_LAT=4 core write.
    txn(1, 0, 1'b1, 32'd9, 32'hAAAA5555, a0, rd0, wr0);
    txn(1, 0, 1'b0, 32'd9, 32'h0, a0, rd0, wr0);
    check("pre_reset_crdata", rdata[1][0], 32'hAAAA5555);
    acks_before = ack_cnt[1][0];
    wcount = 0;
    @(posedge clk); #1;
    req[1][0] = 1'b1; we[1][0] = 1'b1; addr[1][0] = 32'd9; wdata[1][0] = 32'h0BADF00D;
    @(negedge clk); wcount += 32'(m_write[1]);
    @(posedge clk); #1;
    @(negedge clk); wcount += 32'(m_write[1]);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    req[1][0] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_q[1][p].delete();
      last_rd[1][p] = 32'h0;
    end
    #1;
    check("midreset_busy", 32'(busy[1]), 32'h0);
    check("midreset_mwrite", 32'(m_write[1]), 32'h0);
    check("midreset_crdata_cleared", rdata[1][0], 32'h0);
    check("midreset_drdata_cleared", rdata[1][1], 32'h0);
    repeat (3) begin @(negedge clk); wcount += 32'(m_write[1]); end
    rst[1] = 1'b0;
    repeat (6) begin @(negedge clk); wcount += 32'(m_write[1]); end
    check("midreset_no_write", 32'(wcount), 32'h0);
    check("midreset_no_ack", 32'(ack_cnt[1][0] - acks_before), 32'h0);
    txn(1, 0, 1'b0, 32'd9, 32'h0, a0, rd0, wr0);
    check("midreset_mem_kept", rdata[1][0], 32'hAAAA5555);

    // Randomised traffic, core in the low half and debug in the high half.
    for (int k = 0; k < 2; k++) begin
      fork
        rand_port(k, 0, 12);
        rand_port(k, 1, 12);
      join
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty",
          32'(exp_q[0][0].size() + exp_q[0][1].size() + exp_q[1][0].size() + exp_q[1][1].size()),
          32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
